// File: rtl/fpu_issue_scoreboard.sv
// Issue controller and register scoreboard for the multi-cycle FPU.
// A shift pipeline of result slots models writeback timing; busy vectors track pending writes.
module fpu_issue_scoreboard #(
    parameter int unsigned MAX_LAT   = 8,
    parameter int unsigned LAT_FADD  = 5,
    parameter int unsigned LAT_FMUL  = 5,
    parameter int unsigned LAT_FDIV  = 7,
    parameter int unsigned LAT_FSQRT = 3,
    parameter int unsigned LAT_FCVT  = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        flush,
    input  logic        issue_valid,
    output logic        issue_ready,
    input  logic [4:0]  issue_op,
    input  logic [4:0]  issue_rd,
    input  logic        issue_rd_f,
    input  logic [4:0]  issue_rs1,
    input  logic        issue_rs1_f,
    input  logic [4:0]  issue_rs2,
    input  logic        issue_rs2_use,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic        wb_rd_f,
    output logic [4:0]  wb_op,
    output logic [31:0] busy_f,
    output logic [31:0] busy_i
);

    localparam int unsigned REG_W = 5;
    localparam int unsigned OP_W  = 5;
    localparam int unsigned NREG  = 32;
    localparam int unsigned IDX_W = (MAX_LAT < 1) ? 1 : $clog2(MAX_LAT + 1);

    typedef struct packed {
        logic             v;
        logic [REG_W-1:0] rd;
        logic             rd_f;
        logic [OP_W-1:0]  op;
    } slot_t;

    // Every latency must fit inside the completion pipeline
    if (LAT_FADD > MAX_LAT || LAT_FMUL > MAX_LAT || LAT_FDIV > MAX_LAT ||
        LAT_FSQRT > MAX_LAT || LAT_FCVT > MAX_LAT) begin : g_lat_check
        $error("fpu_issue_scoreboard: an op latency exceeds MAX_LAT");
    end

    slot_t            slot_q [MAX_LAT+1];
    slot_t            slot_d [MAX_LAT+1];
    logic [NREG-1:0]  busy_f_q, busy_f_d;
    logic [NREG-1:0]  busy_i_q, busy_i_d;

    int unsigned      lat;
    logic             coll;
    logic             raw;
    logic             waw;
    logic             accept;
    slot_t            new_slot;

    // Per-op latency lookup; unlisted codes complete immediately
    always_comb begin
        lat = 0;
        case (issue_op)
            5'b10000, 5'b10001: lat = LAT_FADD;
            5'b10010:           lat = LAT_FMUL;
            5'b10011:           lat = LAT_FDIV;
            5'b10100:           lat = LAT_FSQRT;
            5'b11100, 5'b11101: lat = LAT_FCVT;
            default:            lat = 0;
        endcase
    end

    // Hazard detection: writeback slot collision, RAW on sources, WAW on destination
    always_comb begin
        coll = 1'b0;
        for (int unsigned k = 0; k < MAX_LAT; k++) begin
            if (lat == k) coll = slot_q[IDX_W'(k + 1)].v;
        end
        raw = (issue_rs1_f ? busy_f_q[issue_rs1] : busy_i_q[issue_rs1]) |
              (issue_rs2_use & busy_f_q[issue_rs2]);
        waw = issue_rd_f ? busy_f_q[issue_rd] : busy_i_q[issue_rd];
        issue_ready = !flush && !coll && !raw && !waw;
        accept      = issue_valid && issue_ready;
    end

    // Next state: shift slots, retire/insert busy bits (insert wins), flush clears everything
    always_comb begin
        new_slot.v    = 1'b1;
        new_slot.rd   = issue_rd;
        new_slot.rd_f = issue_rd_f;
        new_slot.op   = issue_op;
        for (int unsigned k = 0; k < MAX_LAT; k++) begin
            slot_d[IDX_W'(k)] = slot_q[IDX_W'(k + 1)];
        end
        slot_d[IDX_W'(MAX_LAT)] = '0;
        busy_f_d = busy_f_q;
        busy_i_d = busy_i_q;
        if (slot_q[0].v) begin
            if (slot_q[0].rd_f) busy_f_d[slot_q[0].rd] = 1'b0;
            else                busy_i_d[slot_q[0].rd] = 1'b0;
        end
        if (accept) begin
            for (int unsigned k = 0; k <= MAX_LAT; k++) begin
                if (lat == k) slot_d[IDX_W'(k)] = new_slot;
            end
            if (issue_rd_f)              busy_f_d[issue_rd] = 1'b1;
            else if (issue_rd != 5'd0)   busy_i_d[issue_rd] = 1'b1;
        end
        if (flush) begin
            for (int unsigned k = 0; k <= MAX_LAT; k++) begin
                slot_d[IDX_W'(k)] = '0;
            end
            busy_f_d = '0;
            busy_i_d = '0;
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int unsigned k = 0; k <= MAX_LAT; k++) begin
                slot_q[IDX_W'(k)] <= '0;
            end
            busy_f_q <= '0;
            busy_i_q <= '0;
        end else begin
            slot_q   <= slot_d;
            busy_f_q <= busy_f_d;
            busy_i_q <= busy_i_d;
        end
    end

    assign wb_valid = slot_q[0].v;
    assign wb_rd    = slot_q[0].rd;
    assign wb_rd_f  = slot_q[0].rd_f;
    assign wb_op    = slot_q[0].op;
    assign busy_f   = busy_f_q;
    assign busy_i   = busy_i_q;

endmodule
